// File: rtl/clk_div_pkg.sv
// Shared types for the multi-channel clock divider: default counter width, channel FSM states, bus slicing.
// Latency: n/a (types only); backpressure: none.
package clk_div_pkg;

  localparam int CW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } chan_state_e;

  function automatic int slice_lsb(input int c, input int cw);
    return c * cw;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, run/stop FSM, shadowed ratio applied only at a period boundary.
// Latency: first rising edge active+2 cycles after en rises; backpressure: none, strobes always accepted.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int            CW      = CW_DEF,
  parameter logic [CW-1:0] RST_DIV = '0
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          en,
  input  logic          div_load,
  input  logic [CW-1:0] div_val,
  input  logic          sync,
  output logic          div_busy,
  output logic          clk_out,
  output logic          ce_out
);

  chan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] active_q, active_d;
  logic [CW-1:0] shadow_q, shadow_d;
  logic          clk_q, clk_d;
  logic          ce_q, ce_d;
  logic          busy_q, busy_d;
  logic          counting;
  logic          toggle;
  logic          fall;

  always_comb begin
    counting = (state_q != IDLE);
    // >= rather than == so the counter can never run past the active ratio
    toggle   = counting && (cnt_q >= active_q);
    fall     = toggle && clk_q;

    state_d  = state_q;
    cnt_d    = cnt_q;
    clk_d    = clk_q;
    ce_d     = 1'b0;
    active_d = active_q;
    shadow_d = div_load ? div_val : shadow_q;
    busy_d   = busy_q | div_load;

    if (sync) begin
      state_d  = en ? RUN : IDLE;
      cnt_d    = '0;
      clk_d    = 1'b0;
      active_d = div_load ? div_val : (busy_q ? shadow_q : active_q);
      busy_d   = 1'b0;
    end else begin
      if (busy_q && (!counting || fall)) begin
        active_d = shadow_q;
        busy_d   = div_load;
      end

      // en dropping exactly on the falling toggle completes the period there
      unique case (state_q)
        IDLE:     if (en) state_d = RUN;
        RUN:      if (!en) state_d = fall ? IDLE : STOPPING;
        STOPPING: begin
          if (en)        state_d = RUN;
          else if (fall) state_d = IDLE;
        end
        default:  state_d = IDLE;
      endcase

      if (toggle) begin
        cnt_d = '0;
        clk_d = ~clk_q;
        ce_d  = ~clk_q;
      end else if (counting) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      active_q <= RST_DIV;
      shadow_q <= RST_DIV;
      clk_q    <= 1'b0;
      ce_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      clk_q    <= clk_d;
      ce_q     <= ce_d;
      busy_q   <= busy_d;
    end
  end

  assign div_busy = busy_q;
  assign clk_out  = clk_q;
  assign ce_out   = ce_q;

endmodule

// File: rtl/clk_divider_multi.sv
// N-channel programmable even-ratio clock divider, fully synchronous to clk_in with registered outputs.
// Latency: outputs registered, one cycle from any control input; backpressure: none.
module clk_divider_multi
  import clk_div_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int CW      = CW_DEF,
  parameter int RST_DIV = 0
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [NCH-1:0]    en,
  input  logic [NCH*CW-1:0] div_in,
  input  logic [NCH-1:0]    div_load,
  input  logic              sync,
  output logic [NCH-1:0]    div_busy,
  output logic [NCH-1:0]    clk_out,
  output logic [NCH-1:0]    ce_out
);

  localparam logic [CW-1:0] RST_DIV_W = CW'(RST_DIV);

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    clk_div_chan #(
      .CW      (CW),
      .RST_DIV (RST_DIV_W)
    ) u_chan (
      .clk_in   (clk_in),
      .rst      (rst),
      .en       (en[c]),
      .div_load (div_load[c]),
      .div_val  (div_in[slice_lsb(c, CW) +: CW]),
      .sync     (sync),
      .div_busy (div_busy[c]),
      .clk_out  (clk_out[c]),
      .ce_out   (ce_out[c])
    );
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi: per-cycle vector table for start-up and sync alignment,
// then hand-timed sequences for ratio reload, stop, and mid-count reset.
module tb_clk_divider_multi;

  localparam int NCH = 2;
  localparam int CW  = 8;

  logic              clk_in = 1'b0;
  logic              rst;
  logic [NCH-1:0]    en;
  logic [NCH*CW-1:0] div_in;
  logic [NCH-1:0]    div_load;
  logic              sync;
  logic [NCH-1:0]    div_busy;
  logic [NCH-1:0]    clk_out;
  logic [NCH-1:0]    ce_out;

  int n_chk  = 0;
  int n_fail = 0;

  clk_divider_multi #(.NCH(NCH), .CW(CW), .RST_DIV(0)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .en       (en),
    .div_in   (div_in),
    .div_load (div_load),
    .sync     (sync),
    .div_busy (div_busy),
    .clk_out  (clk_out),
    .ce_out   (ce_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [1:0]  en;
    logic [1:0]  ld;
    logic [15:0] dv;
    logic        sy;
    logic [1:0]  e_clk;
    logic [1:0]  e_ce;
    logic [1:0]  e_busy;
  } vec_t;

  localparam int NV = 17;
  vec_t vec [NV];

  function automatic vec_t mk(input logic [1:0] e, input logic [1:0] l, input logic [15:0] d,
                              input logic s, input logic [1:0] ck, input logic [1:0] ce,
                              input logic [1:0] bz);
    vec_t r;
    r.en = e; r.ld = l; r.dv = d; r.sy = s;
    r.e_clk = ck; r.e_ce = ce; r.e_busy = bz;
    return r;
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Steps until clk_out[c] reaches lvl; n = cycles taken, -1 if the bound expired.
  task automatic wait_edge(input int c, input logic lvl, input int max, output int n);
    n = 0;
    while (clk_out[c] !== lvl && n < max) begin
      step();
      n++;
    end
    if (clk_out[c] !== lvl) n = -1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int hi_cnt;
    int ce_cnt;

    vec[0]  = mk(2'b01, 2'b00, 16'h0000, 1'b0, 2'b00, 2'b00, 2'b00);
    vec[1]  = mk(2'b01, 2'b00, 16'h0000, 1'b0, 2'b01, 2'b01, 2'b00);
    vec[2]  = mk(2'b01, 2'b00, 16'h0000, 1'b0, 2'b00, 2'b00, 2'b00);
    vec[3]  = mk(2'b01, 2'b00, 16'h0000, 1'b0, 2'b01, 2'b01, 2'b00);
    vec[4]  = mk(2'b01, 2'b00, 16'h0000, 1'b0, 2'b00, 2'b00, 2'b00);
    vec[5]  = mk(2'b01, 2'b00, 16'h0000, 1'b0, 2'b01, 2'b01, 2'b00);
    vec[6]  = mk(2'b01, 2'b10, 16'h0100, 1'b0, 2'b00, 2'b00, 2'b10);
    vec[7]  = mk(2'b01, 2'b00, 16'h0000, 1'b0, 2'b01, 2'b01, 2'b00);
    vec[8]  = mk(2'b11, 2'b01, 16'h0003, 1'b1, 2'b00, 2'b00, 2'b00);
    vec[9]  = mk(2'b11, 2'b00, 16'h0000, 1'b0, 2'b00, 2'b00, 2'b00);
    vec[10] = mk(2'b11, 2'b00, 16'h0000, 1'b0, 2'b10, 2'b10, 2'b00);
    vec[11] = mk(2'b11, 2'b00, 16'h0000, 1'b0, 2'b10, 2'b00, 2'b00);
    vec[12] = mk(2'b11, 2'b00, 16'h0000, 1'b0, 2'b01, 2'b01, 2'b00);
    vec[13] = mk(2'b11, 2'b00, 16'h0000, 1'b0, 2'b01, 2'b00, 2'b00);
    vec[14] = mk(2'b11, 2'b00, 16'h0000, 1'b0, 2'b11, 2'b10, 2'b00);
    vec[15] = mk(2'b11, 2'b00, 16'h0000, 1'b0, 2'b11, 2'b00, 2'b00);
    vec[16] = mk(2'b11, 2'b00, 16'h0000, 1'b0, 2'b00, 2'b00, 2'b00);

    rst = 1'b1; en = 2'b01; div_in = '0; div_load = '0; sync = 1'b0;
    step();
    step();
    chk("reset clk_out", int'(clk_out), 0);
    chk("reset ce_out", int'(ce_out), 0);
    chk("reset div_busy", int'(div_busy), 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      en = vec[i].en; div_load = vec[i].ld; div_in = vec[i].dv; sync = vec[i].sy;
      step();
      chk($sformatf("vec%0d clk_out", i), int'(clk_out), int'(vec[i].e_clk));
      chk($sformatf("vec%0d ce_out", i), int'(ce_out), int'(vec[i].e_ce));
      chk($sformatf("vec%0d div_busy", i), int'(div_busy), int'(vec[i].e_busy));
    end
    div_load = '0; sync = 1'b0;

    // Reload 3 -> 9 during the high phase: old period finishes, then /20.
    wait_edge(0, 1'b1, 40, n);  chk("reload low phase", n, 4);
    step();
    div_load = 2'b01; div_in = 16'h0009;
    step();
    div_load = '0;
    chk("reload busy set", int'(div_busy[0]), 1);
    wait_edge(0, 1'b0, 40, n);  chk("reload high phase tail", n, 2);
    chk("reload busy clear", int'(div_busy[0]), 0);
    wait_edge(0, 1'b1, 40, n);  chk("ratio9 low phase", n, 10);
    wait_edge(0, 1'b0, 40, n);  chk("ratio9 high phase", n, 10);

    // Two loads in one period: only the last (2) is applied.
    div_load = 2'b01; div_in = 16'h0005;
    step();
    div_load = '0;
    step();
    div_load = 2'b01; div_in = 16'h0002;
    step();
    div_load = '0;
    chk("double load busy", int'(div_busy[0]), 1);
    wait_edge(0, 1'b1, 40, n);  chk("double load rise", n, 7);
    wait_edge(0, 1'b0, 40, n);  chk("double load fall", n, 10);
    chk("double load busy clear", int'(div_busy[0]), 0);
    wait_edge(0, 1'b1, 40, n);  chk("ratio2 low phase", n, 3);
    wait_edge(0, 1'b0, 40, n);  chk("ratio2 high phase", n, 3);

    // Stop mid-high-phase at div=4: high phase still lasts 5 cycles, then held low.
    en = 2'b11; sync = 1'b1; div_load = 2'b01; div_in = 16'h0004;
    step();
    sync = 1'b0; div_load = '0;
    chk("sync clk_out", int'(clk_out), 0);
    wait_edge(0, 1'b1, 40, n);  chk("div4 first rise", n, 5);
    step();
    step();
    en = 2'b10;
    wait_edge(0, 1'b0, 40, n);  chk("stop high phase remainder", n, 3);
    hi_cnt = 0; ce_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (clk_out[0] === 1'b1) hi_cnt++;
      if (ce_out[0] === 1'b1) ce_cnt++;
    end
    chk("stopped clk_out high cycles", hi_cnt, 0);
    chk("stopped ce_out pulses", ce_cnt, 0);
    en = 2'b11;
    wait_edge(0, 1'b1, 40, n);  chk("restart latency from idle", n, 6);
    chk("restart ce_out", int'(ce_out[0]), 1);

    // Asynchronous reset mid-count with a ratio pending on ch1.
    step();
    div_load = 2'b10; div_in = 16'h0700;
    step();
    div_load = '0;
    chk("pre-reset clk_out ch0", int'(clk_out[0]), 1);
    chk("pre-reset busy", int'(div_busy), 2);
    #2 rst = 1'b1;
    #1;
    chk("async reset clk_out", int'(clk_out), 0);
    chk("async reset ce_out", int'(ce_out), 0);
    chk("async reset div_busy", int'(div_busy), 0);
    rst = 1'b0;
    step();
    chk("post-reset idle->run", int'(clk_out), 0);
    step();
    chk("post-reset first rise", int'(clk_out), 3);
    chk("post-reset first ce", int'(ce_out), 3);
    step();
    chk("post-reset div2 fall", int'(clk_out), 0);
    chk("post-reset ce clear", int'(ce_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
